// File: rtl/decode_nw.sv
// decode_nw: N-wide decode stage with a 2-entry OUT/SKID buffer between fetch and rename.
// Define DECODE_ILLEGAL_TRAP_EN to keep illegal lanes as traps (illegal_mask) instead of dropping them.
package decode_nw_pkg;
    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_INST_BITS = 32;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_ARI_I  = 7'h13;
    localparam logic [6:0] OP_ARI_R  = 7'h33;
    localparam logic [6:0] OP_CSR    = 7'h73;
    localparam logic [6:0] FNC7_MULDIV  = 7'h01;
    localparam logic [6:0] FNC7_SUB_SRA = 7'h20;
    localparam logic [2:0] F3_SRL_SRA   = 3'b101;
    localparam logic [3:0] UOP_ADD      = 4'h0;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc;
        logic                     is_valid;
        logic                     has_rd;
        logic [4:0]               rd;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [31:0]              imm;
        logic                     alu_a_sel;
        logic                     alu_b_sel;
        logic                     is_branch;
        logic                     is_jump;
        logic                     is_load;
        logic                     is_store;
        logic                     is_muldiv;
        logic [3:0]               uop;
        logic [2:0]               uop_br;
    } decoded_inst_t;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_LOAD, OP_STORE, OP_ARI_I, OP_ARI_R, OP_CSR};
    endfunction

    function automatic decoded_inst_t decode(input logic [CPU_ADDR_BITS-1:0] pc,
                                             input logic [CPU_INST_BITS-1:0] i);
        decoded_inst_t d;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        d = '0;
        d.pc        = pc;
        d.rd        = i[11:7];
        d.rs1       = i[19:15];
        d.rs2       = i[24:20];
        d.is_valid  = is_legal(op);
        // x0 destinations never reach rename
        d.has_rd    = (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_ARI_I, OP_ARI_R}) && i[11:7] != 5'd0;
        d.imm       = (op inside {OP_ARI_I, OP_LOAD, OP_JALR}) ? {{20{i[31]}}, i[31:20]} :
                      op == OP_STORE  ? {{20{i[31]}}, i[31:25], i[11:7]} :
                      op == OP_BRANCH ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
                      (op inside {OP_LUI, OP_AUIPC}) ? {i[31:12], 12'h000} :
                      op == OP_JAL    ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'h0;
        d.alu_a_sel = op inside {OP_AUIPC, OP_JAL, OP_BRANCH};
        d.alu_b_sel = op != OP_ARI_R;
        d.is_branch = op == OP_BRANCH;
        d.is_jump   = op == OP_JAL || op == OP_JALR;
        d.is_load   = op == OP_LOAD;
        d.is_store  = op == OP_STORE;
        d.is_muldiv = op == OP_ARI_R && f7 == FNC7_MULDIV;
        d.uop       = (op == OP_ARI_R || op == OP_ARI_I) ?
                          {f7 == FNC7_SUB_SRA && (op == OP_ARI_R || f3 == F3_SRL_SRA), f3} :
                      (op == OP_LOAD || op == OP_STORE) ? {1'b0, f3} : UOP_ADD;
        d.uop_br    = op == OP_BRANCH ? f3 : 3'b000;
        return d;
    endfunction
endpackage

module decode_nw
    import decode_nw_pkg::*;
#(
    parameter int DECODE_WIDTH = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         flush,
    output logic                                         decode_rdy,
    input  logic [DECODE_WIDTH-1:0][CPU_ADDR_BITS-1:0]   inst_pc,
    input  logic [DECODE_WIDTH-1:0][CPU_INST_BITS-1:0]   inst,
    input  logic [DECODE_WIDTH-1:0]                      inst_val,
    input  logic                                         rename_rdy,
    output decoded_inst_t [DECODE_WIDTH-1:0]             decode_inst,
    output logic                                         decode_val,
    output logic [DECODE_WIDTH-1:0]                      illegal_mask
);
    typedef struct packed {
        decoded_inst_t [DECODE_WIDTH-1:0] l;
        logic [DECODE_WIDTH-1:0]          ill;
    } bundle_t;

    bundle_t dec, out_q, skid_q, out_n, skid_n;
    logic out_full, skid_full, in_fire, out_fire, sk2o, to_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic sq;
`endif

    always_comb begin
        dec = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        sq = 1'b0;
`endif
        for (int k = 0; k < DECODE_WIDTH; k++) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            // first illegal lane becomes a trap carrier; younger lanes are squashed
            if (inst_val[k] && !sq) begin
                if (is_legal(inst[k][6:0])) begin
                    dec.l[k] = decode(inst_pc[k], inst[k]);
                end else begin
                    dec.l[k].is_valid = 1'b1;
                    dec.l[k].pc       = inst_pc[k];
                    dec.l[k].rd       = inst[k][11:7];
                    dec.l[k].rs1      = inst[k][19:15];
                    dec.l[k].rs2      = inst[k][24:20];
                    dec.ill[k]        = 1'b1;
                    sq                = 1'b1;
                end
            end
`else
            if (inst_val[k] && is_legal(inst[k][6:0])) dec.l[k] = decode(inst_pc[k], inst[k]);
`endif
        end
    end

    always_comb begin
        out_full  = 1'b0;
        skid_full = 1'b0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            out_full  |= out_q.l[k].is_valid;
            skid_full |= skid_q.l[k].is_valid;
        end
    end

    assign decode_rdy   = !skid_full;
    assign decode_val   = out_full;
    assign decode_inst  = out_q.l;
    assign illegal_mask = out_q.ill;
    assign in_fire      = |inst_val && decode_rdy;
    assign out_fire     = decode_val && rename_rdy;
    assign sk2o         = out_fire && skid_full;
    assign to_out       = in_fire && (!out_full || out_fire);

    always_comb begin
        out_n  = sk2o ? skid_q : to_out ? dec : out_fire ? '0 : out_q;
        skid_n = sk2o ? '0 : (in_fire && !to_out) ? dec : skid_q;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_n;
            skid_q <= skid_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert ((inst_val & (inst_val + 1'b1)) == '0);
    end
endmodule

// File: tb/tb_decode_nw.sv
// tb_decode_nw: vector table, hand sequences for buffering/flush, and randomized run against a queue model.
module tb_decode_nw;
    import decode_nw_pkg::*;
    localparam int W = 2;
    localparam logic [31:0] ADD = 32'h002081B3;
    localparam logic [6:0] OPS [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                        7'h23, 7'h13, 7'h33, 7'h73, 7'h7F, 7'h0B};

    logic clk = 1'b0;
    logic rst, flush, decode_rdy, rename_rdy, decode_val;
    logic [W-1:0][31:0] inst_pc, inst;
    logic [W-1:0] inst_val, illegal_mask;
    decoded_inst_t [W-1:0] decode_inst;

    typedef struct packed {
        decoded_inst_t [W-1:0] l;
        logic [W-1:0]          ill;
    } exp_t;

    typedef struct {
        logic [31:0] i0, i1;
        logic [1:0]  val;
        logic [31:0] imm0;
        logic [3:0]  uop0;
        logic [8:0]  fl0;
        logic [2:0]  br0;
        logic        v1, hr1;
        logic [31:0] imm1;
        logic [1:0]  ill;
    } vec_t;

    vec_t tv [16];
    exp_t q [$];
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    decode_nw #(.DECODE_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .decode_rdy(decode_rdy),
        .inst_pc(inst_pc), .inst(inst), .inst_val(inst_val), .rename_rdy(rename_rdy),
        .decode_inst(decode_inst), .decode_val(decode_val), .illegal_mask(illegal_mask)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc);
        inst_pc[0] = pc;
        inst_pc[1] = pc + 32'd4;
        inst[0] = ADD;
        inst[1] = ADD;
        inst_val = 2'b11;
    endtask

    function automatic logic [8:0] flags(input decoded_inst_t d);
        return {d.is_valid, d.has_rd, d.alu_a_sel, d.alu_b_sel, d.is_branch,
                d.is_jump, d.is_load, d.is_store, d.is_muldiv};
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    endfunction

    // reference decode written directly from the per-opcode rules
    function automatic decoded_inst_t ref_lane(input logic [31:0] pc, input logic [31:0] ins);
        decoded_inst_t d;
        logic wr;
        int v;
        d = '0;
        wr = 1'b0;
        d.pc = pc;
        d.rd = ins[11:7];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.is_valid = 1'b1;
        d.alu_b_sel = 1'b1;
        case (ins[6:0])
            7'h37: begin d.imm = {ins[31:12], 12'h0}; wr = 1; end
            7'h17: begin d.imm = {ins[31:12], 12'h0}; wr = 1; d.alu_a_sel = 1; end
            7'h6F: begin
                v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                d.imm = v; wr = 1; d.alu_a_sel = 1; d.is_jump = 1;
            end
            7'h67: begin v = $signed(ins[31:20]); d.imm = v; wr = 1; d.is_jump = 1; end
            7'h63: begin
                v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                d.imm = v; d.alu_a_sel = 1; d.is_branch = 1; d.uop_br = ins[14:12];
            end
            7'h03: begin v = $signed(ins[31:20]); d.imm = v; wr = 1; d.is_load = 1; d.uop = {1'b0, ins[14:12]}; end
            7'h23: begin v = $signed({ins[31:25], ins[11:7]}); d.imm = v; d.is_store = 1; d.uop = {1'b0, ins[14:12]}; end
            7'h13: begin
                v = $signed(ins[31:20]); d.imm = v; wr = 1;
                d.uop = {ins[14:12] == 3'd5 && ins[31:25] == 7'h20, ins[14:12]};
            end
            7'h33: begin
                wr = 1; d.alu_b_sel = 0; d.is_muldiv = ins[31:25] == 7'h01;
                d.uop = {ins[31:25] == 7'h20, ins[14:12]};
            end
            default: ;
        endcase
        d.has_rd = wr && ins[11:7] != 5'd0;
        return d;
    endfunction

    function automatic exp_t ref_bundle(input logic [W-1:0][31:0] pcs, input logic [W-1:0][31:0] ins,
                                        input logic [W-1:0] val);
        exp_t e;
        logic dead;
        e = '0;
        dead = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (val[k] && !dead) begin
                if (legal(ins[k][6:0])) e.l[k] = ref_lane(pcs[k], ins[k]);
                else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                    e.l[k].is_valid = 1'b1;
                    e.l[k].pc = pcs[k];
                    e.l[k].rd = ins[k][11:7];
                    e.l[k].rs1 = ins[k][19:15];
                    e.l[k].rs2 = ins[k][24:20];
                    e.ill[k] = 1'b1;
                    dead = 1'b1;
`endif
                end
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 2) == 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h01;
        r[6:0] = ($urandom_range(0, 9) == 0) ? OPS[$urandom_range(10, 11)] : OPS[$urandom_range(0, 9)];
        return r;
    endfunction

    initial begin
        tv[0]  = '{32'h002081B3, 32'hFFF00293, 2'b11, 32'h0,        4'h0, 9'b110000000, 3'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 2'b00};
        tv[1]  = '{32'hFE208CE3, ADD,          2'b01, 32'hFFFFFFF8, 4'h0, 9'b101110000, 3'd0, 1'b0, 1'b0, 32'h0,        2'b00};
        tv[2]  = '{32'h40208233, 32'h4030D313, 2'b11, 32'h0,        4'h8, 9'b110000000, 3'd0, 1'b1, 1'b1, 32'h00000403, 2'b00};
        tv[3]  = '{32'h4030D313, 32'h01012483, 2'b11, 32'h00000403, 4'hD, 9'b110100000, 3'd0, 1'b1, 1'b1, 32'h00000010, 2'b00};
        tv[4]  = '{32'h40008393, 32'h02208433, 2'b11, 32'h00000400, 4'h0, 9'b110100000, 3'd0, 1'b1, 1'b1, 32'h0,        2'b00};
        tv[5]  = '{32'h02208433, 32'hFE312E23, 2'b11, 32'h0,        4'h0, 9'b110000001, 3'd0, 1'b1, 1'b0, 32'hFFFFFFFC, 2'b00};
        tv[6]  = '{32'h01012483, ADD,          2'b01, 32'h00000010, 4'h2, 9'b110100100, 3'd0, 1'b0, 1'b0, 32'h0,        2'b00};
        tv[7]  = '{32'hFE312E23, 32'h12345537, 2'b11, 32'hFFFFFFFC, 4'h2, 9'b100100010, 3'd0, 1'b1, 1'b1, 32'h12345000, 2'b00};
        tv[8]  = '{32'h12345537, 32'hFFFFF017, 2'b11, 32'h12345000, 4'h0, 9'b110100000, 3'd0, 1'b1, 1'b0, 32'hFFFFF000, 2'b00};
        tv[9]  = '{32'hFFFFF017, 32'hFFDFF0EF, 2'b11, 32'hFFFFF000, 4'h0, 9'b101100000, 3'd0, 1'b1, 1'b1, 32'hFFFFFFFC, 2'b00};
        tv[10] = '{32'hFFDFF0EF, 32'h00008067, 2'b11, 32'hFFFFFFFC, 4'h0, 9'b111101000, 3'd0, 1'b1, 1'b0, 32'h0,        2'b00};
        tv[11] = '{32'h00008067, 32'h300092F3, 2'b11, 32'h0,        4'h0, 9'b100101000, 3'd0, 1'b1, 1'b0, 32'h0,        2'b00};
        tv[12] = '{32'h300092F3, 32'h00009863, 2'b11, 32'h0,        4'h0, 9'b100100000, 3'd0, 1'b1, 1'b0, 32'h00000010, 2'b00};
        tv[13] = '{32'h00009863, ADD,          2'b01, 32'h00000010, 4'h0, 9'b101110000, 3'd1, 1'b0, 1'b0, 32'h0,        2'b00};
`ifdef DECODE_ILLEGAL_TRAP_EN
        tv[14] = '{32'h0000007F, ADD,          2'b11, 32'h0,        4'h0, 9'b100000000, 3'd0, 1'b0, 1'b0, 32'h0,        2'b01};
        tv[15] = '{ADD,          32'h0000007F, 2'b11, 32'h0,        4'h0, 9'b110000000, 3'd0, 1'b1, 1'b0, 32'h0,        2'b10};
`else
        tv[14] = '{32'h0000007F, ADD,          2'b11, 32'h0,        4'h0, 9'b000000000, 3'd0, 1'b1, 1'b1, 32'h0,        2'b00};
        tv[15] = '{ADD,          32'h0000007F, 2'b11, 32'h0,        4'h0, 9'b110000000, 3'd0, 1'b0, 1'b0, 32'h0,        2'b00};
`endif
        rst = 1'b1; flush = 1'b0; rename_rdy = 1'b0; inst_val = '0; inst = '0; inst_pc = '0;
        repeat (2) tick();
        chk("rst_val", 128'(decode_val), 128'(1'b0));
        chk("rst_rdy", 128'(decode_rdy), 128'(1'b1));
        chk("rst_ill", 128'(illegal_mask), 128'(2'b00));
        for (int k = 0; k < W; k++) chk($sformatf("rst_lane%0d", k), 128'(decode_inst[k]), 128'(0));
        rst = 1'b0;
        rename_rdy = 1'b1;
        for (int n = 0; n < 16; n++) begin
            inst[0] = tv[n].i0;
            inst[1] = tv[n].i1;
            inst_val = tv[n].val;
            inst_pc[0] = 32'h1000 + 32'(n * 8);
            inst_pc[1] = inst_pc[0] + 32'd4;
            tick();
            inst_val = '0;
            chk($sformatf("tv%0d_val", n), 128'(decode_val), 128'(1'b1));
            chk($sformatf("tv%0d_flags0", n), 128'(flags(decode_inst[0])), 128'(tv[n].fl0));
            chk($sformatf("tv%0d_imm0", n), 128'(decode_inst[0].imm), 128'(tv[n].imm0));
            chk($sformatf("tv%0d_uop0", n), 128'(decode_inst[0].uop), 128'(tv[n].uop0));
            chk($sformatf("tv%0d_br0", n), 128'(decode_inst[0].uop_br), 128'(tv[n].br0));
            chk($sformatf("tv%0d_pc0", n), 128'(decode_inst[0].pc), 128'(tv[n].fl0[8] ? inst_pc[0] : 32'h0));
            chk($sformatf("tv%0d_v1", n), 128'(decode_inst[1].is_valid), 128'(tv[n].v1));
            chk($sformatf("tv%0d_hr1", n), 128'(decode_inst[1].has_rd), 128'(tv[n].hr1));
            chk($sformatf("tv%0d_imm1", n), 128'(decode_inst[1].imm), 128'(tv[n].imm1));
            chk($sformatf("tv%0d_pc1", n), 128'(decode_inst[1].pc), 128'(tv[n].v1 ? inst_pc[1] : 32'h0));
            chk($sformatf("tv%0d_ill", n), 128'(illegal_mask), 128'(tv[n].ill));
            tick();
            chk($sformatf("tv%0d_drain", n), 128'(decode_val), 128'(1'b0));
        end
        rename_rdy = 1'b0;
        drive(32'hA00); tick();
        chk("bp_a_val", 128'(decode_val), 128'(1'b1));
        chk("bp_a_rdy", 128'(decode_rdy), 128'(1'b1));
        drive(32'hB00); tick();
        chk("bp_b_rdy", 128'(decode_rdy), 128'(1'b0));
        chk("bp_b_pc", 128'(decode_inst[0].pc), 128'(32'hA00));
        drive(32'hC00); tick();
        chk("bp_c_rdy", 128'(decode_rdy), 128'(1'b0));
        chk("bp_c_pc", 128'(decode_inst[0].pc), 128'(32'hA00));
        rename_rdy = 1'b1; tick();
        chk("bp_out_b", 128'(decode_inst[0].pc), 128'(32'hB00));
        chk("bp_out_b_rdy", 128'(decode_rdy), 128'(1'b1));
        tick();
        inst_val = '0;
        chk("bp_out_c", 128'(decode_inst[0].pc), 128'(32'hC00));
        chk("bp_out_c_val", 128'(decode_val), 128'(1'b1));
        tick();
        chk("bp_empty", 128'(decode_val), 128'(1'b0));
        rename_rdy = 1'b0;
        drive(32'hD00); tick();
        drive(32'hE00); tick();
        chk("fl_full_rdy", 128'(decode_rdy), 128'(1'b0));
        flush = 1'b1;
        drive(32'hF00); tick();
        flush = 1'b0;
        inst_val = '0;
        chk("fl_val", 128'(decode_val), 128'(1'b0));
        chk("fl_rdy", 128'(decode_rdy), 128'(1'b1));
        chk("fl_ill", 128'(illegal_mask), 128'(2'b00));
        chk("fl_lane0", 128'(decode_inst[0]), 128'(0));
        rename_rdy = 1'b1;
        repeat (2) begin
            tick();
            chk("fl_gone", 128'(decode_val), 128'(1'b0));
        end
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            exp_t e;
            logic rdy, of, inf;
            flush = ($urandom_range(0, 31) == 0);
            rename_rdy = ($urandom_range(0, 2) != 0);
            inst_val = W'((1 << $urandom_range(0, W)) - 1);
            for (int k = 0; k < W; k++) begin
                inst[k] = rnd_inst();
                inst_pc[k] = $urandom & 32'hFFFFFFFC;
            end
            e = ref_bundle(inst_pc, inst, inst_val);
            @(posedge clk);
            if (flush) q.delete();
            else begin
                rdy = q.size() < 2;
                of = q.size() > 0 && rename_rdy;
                inf = |inst_val && rdy;
                if (of) void'(q.pop_front());
                if (inf && (e.l[0].is_valid || e.l[1].is_valid)) q.push_back(e);
            end
            #1;
            chk("rnd_val", 128'(decode_val), 128'(q.size() > 0));
            chk("rnd_rdy", 128'(decode_rdy), 128'(q.size() < 2));
            chk("rnd_ill", 128'(illegal_mask), 128'(q.size() > 0 ? q[0].ill : 2'b00));
            if (q.size() > 0)
                for (int k = 0; k < W; k++)
                    chk($sformatf("rnd%0d_lane%0d", n, k), 128'(decode_inst[k]), 128'(q[0].l[k]));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
